systolic_array_sequencer: RTL
=============================

Name: systolic_array_sequencer

Overview:
Control block that runs one matrix product C = A·B (A is array_height_p x k, B is k x array_width_p) on the systolic_array datapath. It clears the accumulators with flush, then streams operands into the row and column lanes with the required diagonal skew under per-lane valid/ready. It waits for every MAC's z_valid, then presents one result event upstream and pops the array with z_yumi. Operands are read combinationally from external operand storage, addressed per lane.

Parameters:
width_p, 32, operand/accumulator width
array_width_p, 2, columns (col lanes)
array_height_p, 2, rows (row lanes)
max_k_p, 8, maximum inner dimension
timeout_p, 64, cycles allowed in DRAIN before error
idx_w_lp (derived), $clog2(max_k_p), index width

Ports:
clk_i  in  1  clock
reset_ni  in  1  reset, asynchronous, active-low
start_i  in  1  begin product; sampled in IDLE only
k_len_i  in  idx_w_lp+1  inner dimension k, 1..max_k_p, captured on start
busy_o  out  1  high in every state except IDLE
a_idx_o  out  array_height_p*idx_w_lp  per row lane r: k index of A[r][*] requested
a_data_i  in  array_height_p*width_p  per lane: A[r][a_idx] (combinational)
b_idx_o  out  array_width_p*idx_w_lp  per col lane c: k index of B[*][c] requested
b_data_i  in  array_width_p*width_p  per lane: B[b_idx][c] (combinational)
flush_o  out  array_height_p  to array flush_i
row_o  out  array_height_p*width_p  to array row_i
row_valid_o  out  array_height_p  to array row_valid_i
row_ready_i  in  array_height_p  from array row_ready_o
col_o  out  array_width_p*width_p  to array col_i
col_valid_o  out  array_width_p  to array col_valid_i
col_ready_i  in  array_width_p  from array col_ready_o
z_valid_i  in  array_height_p*array_width_p  from array
z_yumi_o  out  array_height_p*array_width_p  to array
res_valid_o  out  1  all results in array valid
res_yumi_i  in  1  consumer took results (only legal while res_valid_o)
error_o  out  1  sticky timeout flag

Behaviour:
- Clock is clk_i. reset_ni is asynchronous and active-low. Reset forces IDLE, step counter 0, k register 0, timeout counter 0, error_o 0. Every output is 0 during reset, including idx outputs.
- States: IDLE -> FLUSH -> FEED -> DRAIN -> RESULT -> IDLE.
- IDLE: start_i=1 captures k_len_i, clears error_o, and moves to FLUSH. A k_len_i of 0 or greater than max_k_p is clamped to max_k_p. start_i is ignored in every other state.
- FLUSH: flush_o is all ones for exactly one cycle, with no valids asserted. Next state is FEED with step t=0.
- FEED:
  - Row lane r is active when r <= t <= r+k-1; a_idx_o[r]=t-r. Column lane c is active when c <= t <= c+k-1; b_idx_o[c]=t-c.
  - Active lanes drive data from a_data_i/b_data_i with valid=1. Inactive lanes drive data 0, valid 0, idx 0.
  - t advances only when every active lane has ready=1 in that cycle (per-lane transfer on valid&ready). Otherwise all outputs hold unchanged; no partial advance.
  - Last step is T=k-1+max(array_height_p,array_width_p)-1. When step T transfers, next state is DRAIN and the timeout counter is cleared.
- DRAIN: all valids 0. When &z_valid_i=1, go to RESULT. If the counter reaches timeout_p-1 without that, set error_o=1 and go to IDLE (no yumi).
- RESULT: res_valid_o=1. When res_yumi_i=1, z_yumi_o is all ones in that same cycle (combinational from res_yumi_i&res_valid_o), and the next state is IDLE. res_valid_o holds indefinitely without yumi.
- busy_o=1 in FLUSH, FEED, DRAIN and RESULT.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs 0. The array's own reset is the system's responsibility.
- No arithmetic on data: operands pass through unchanged, width_p bits, two's complement.

Test Plan:
- 2x2, k=2, A={{13,45},{6,27}}, B={{83,9},{22,1}}, ready all 1 -> sequence is:
  - flush_o=2'b11 for one cycle.
  - t0: row0=13, col0=83, valid 01/01.
  - t1: rows {6,45}, cols {9,22}, valid 11/11.
  - t2: row1=27, col1=1, valid 10/10.
  - Then DRAIN; with the real array, z={{2069,162},{1092,81}} and res_valid_o=1.
- Same product with row_ready_i[1]=0 for 3 cycles at t1 -> outputs frozen at t1 values for 3 cycles, then proceed; final results unchanged.
- A={{-37,44},{10,960}}, B={{83,99},{22,-1}}, res_yumi_i held 0 for 5 cycles -> res_valid_o stays 1, z_yumi_o=0. On yumi: z_yumi_o=4'b1111 for one cycle, then IDLE; C={{-2103,-3707},{21950,30}}.
- z_valid_i tied 0 -> error_o=1 exactly timeout_p cycles after entering DRAIN, return to IDLE; next start_i clears error_o.
- reset_ni pulsed low during FEED t1 -> all outputs 0 asynchronously, IDLE, busy_o=0; a subsequent 3x3 run with k=3 completes with last feed at t=4.
- start_i pulsed in FEED and RESULT -> ignored; k_len_i=0 -> runs with k=max_k_p (last step t=max_k_p).

Source files
------------

// File: rtl/systolic_array_sequencer_if.sv
// Lane bundle between the sequencer (master) and the systolic_array (slave).
// Handshake: a lane word moves on a cycle where its valid and ready are both high; valid never waits on ready.
interface systolic_array_sequencer_if #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
);
    logic [array_height_p-1:0]               flush_o;
    logic [array_height_p*width_p-1:0]       row_o;
    logic [array_height_p-1:0]               row_valid_o;
    logic [array_height_p-1:0]               row_ready_i;
    logic [array_width_p*width_p-1:0]        col_o;
    logic [array_width_p-1:0]                col_valid_o;
    logic [array_width_p-1:0]                col_ready_i;
    logic [array_height_p*array_width_p-1:0] z_valid_i;
    logic [array_height_p*array_width_p-1:0] z_yumi_o;

    modport master (
        output flush_o, row_o, row_valid_o, col_o, col_valid_o, z_yumi_o,
        input  row_ready_i, col_ready_i, z_valid_i
    );

    modport slave (
        input  flush_o, row_o, row_valid_o, col_o, col_valid_o, z_yumi_o,
        output row_ready_i, col_ready_i, z_valid_i
    );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Runs one C = A*B on the systolic array: flush, skewed operand feed, drain wait, result pop.
module systolic_array_sequencer #(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int max_k_p        = 8,
    parameter int timeout_p      = 64,
    localparam int idx_w_lp      = $clog2(max_k_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_ni,
    input  logic                                start_i,
    input  logic [idx_w_lp:0]                   k_len_i,
    output logic                                busy_o,
    output logic [array_height_p*idx_w_lp-1:0]  a_idx_o,
    input  logic [array_height_p*width_p-1:0]   a_data_i,
    output logic [array_width_p*idx_w_lp-1:0]   b_idx_o,
    input  logic [array_width_p*width_p-1:0]    b_data_i,
    systolic_array_sequencer_if.master          arr_if,
    output logic                                res_valid_o,
    input  logic                                res_yumi_i,
    output logic                                error_o,
    output logic [2:0]                          state_o
);
    localparam int max_dim_lp = (array_height_p > array_width_p) ? array_height_p : array_width_p;
    localparam int step_w_lp  = $clog2(max_k_p + max_dim_lp);
    localparam int tmo_w_lp   = $clog2(timeout_p);
    localparam int kw_lp      = idx_w_lp + 1;
    localparam int n_mac_lp   = array_height_p * array_width_p;

    typedef enum logic [2:0] {IDLE, FLUSH, FEED, DRAIN, RESULT} state_e;

    state_e               state_q, state_d;
    logic [step_w_lp-1:0] step_q, step_d;
    logic [kw_lp-1:0]     k_q, k_d;
    logic [tmo_w_lp-1:0]  tmo_q, tmo_d;
    logic                 error_q, error_d;
    logic [array_height_p-1:0] row_act;
    logic [array_width_p-1:0]  col_act;
    logic                 feed_go;
    logic                 last_step;

    assign state_o = state_q;
    assign error_o = error_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            step_q  <= '0;
            k_q     <= '0;
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            k_q     <= k_d;
            tmo_q   <= tmo_d;
            error_q <= error_d;
        end
    end

    // Lane r (or c) carries operand index t-r during the k steps starting at t=r: the diagonal skew.
    always_comb begin
        row_act            = '0;
        col_act            = '0;
        a_idx_o            = '0;
        b_idx_o            = '0;
        arr_if.row_o       = '0;
        arr_if.col_o       = '0;
        for (int r = 0; r < array_height_p; r++) begin
            row_act[r] = (state_q == FEED) && (int'(step_q) >= r) && (int'(step_q) < r + int'(k_q));
            if (row_act[r]) begin
                a_idx_o[r*idx_w_lp +: idx_w_lp]  = idx_w_lp'(int'(step_q) - r);
                arr_if.row_o[r*width_p +: width_p] = a_data_i[r*width_p +: width_p];
            end
        end
        for (int c = 0; c < array_width_p; c++) begin
            col_act[c] = (state_q == FEED) && (int'(step_q) >= c) && (int'(step_q) < c + int'(k_q));
            if (col_act[c]) begin
                b_idx_o[c*idx_w_lp +: idx_w_lp]  = idx_w_lp'(int'(step_q) - c);
                arr_if.col_o[c*width_p +: width_p] = b_data_i[c*width_p +: width_p];
            end
        end
        arr_if.row_valid_o = row_act;
        arr_if.col_valid_o = col_act;
    end

    // A step completes only when every lane that is presenting data is accepted; idle lanes never stall.
    assign feed_go   = ((arr_if.row_ready_i | ~row_act) == '1) && ((arr_if.col_ready_i | ~col_act) == '1);
    assign last_step = (int'(step_q) == int'(k_q) + max_dim_lp - 2);

    always_comb begin
        state_d         = state_q;
        step_d          = step_q;
        k_d             = k_q;
        tmo_d           = tmo_q;
        error_d         = error_q;
        busy_o          = (state_q != IDLE);
        arr_if.flush_o  = '0;
        arr_if.z_yumi_o = '0;
        res_valid_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (k_len_i == '0 || int'(k_len_i) > max_k_p) begin
                        k_d = kw_lp'(max_k_p);
                    end else begin
                        k_d = k_len_i;
                    end
                    error_d = 1'b0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                arr_if.flush_o = '1;
                step_d         = '0;
                state_d        = FEED;
            end
            FEED: begin
                if (feed_go) begin
                    if (last_step) begin
                        tmo_d   = '0;
                        state_d = DRAIN;
                    end else begin
                        step_d = step_q + step_w_lp'(1);
                    end
                end
            end
            DRAIN: begin
                if (&arr_if.z_valid_i) begin
                    state_d = RESULT;
                end else if (tmo_q == tmo_w_lp'(timeout_p - 1)) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + tmo_w_lp'(1);
                end
            end
            RESULT: begin
                res_valid_o     = 1'b1;
                arr_if.z_yumi_o = {n_mac_lp{res_yumi_i}};
                if (res_yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
